flex_counter_updown: RTL and testbench
======================================

Name: flex_counter_updown

Overview:
- Parametrised successor to the team's flexible rollover counter.
- Adds up/down direction, synchronous load, wrap or saturate mode, a wrap-event pulse, a wrap-event counter and configuration-error detection.
- Used as the general bit/baud/byte counter in the UART datapath and timers.
- Single clock domain; synchronous active-high reset.

Parameters:
NUM_CNT_BITS, 4, width of count_out, load_val and rollover_val
WRAP_BITS, 8, width of wrap_count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous clear of count, flags and wrap_count
count_enable  input  1  advance counter one step this cycle
count_down  input  1  0 = count up, 1 = count down
sat_mode  input  1  0 = wrap at terminal, 1 = saturate at terminal
load  input  1  synchronous load of load_val
load_val  input  NUM_CNT_BITS  value loaded into count_out
rollover_val  input  NUM_CNT_BITS  upper terminal value R (must be nonzero)
count_out  output  NUM_CNT_BITS  current count
rollover_flag  output  1  high while count_out equals terminal of current direction
wrap_pulse  output  1  one-cycle pulse, coincident with count_out showing a wrap result
wrap_count  output  WRAP_BITS  number of wraps since reset/clear, saturating
cfg_err  output  1  sticky: a count step was attempted with rollover_val == 0

Behaviour:
- Reset (rst=1 at clk edge): count_out=0, rollover_flag=0, wrap_pulse=0, wrap_count=0, cfg_err=0, prescaler=0. Reset is synchronous only; mid-operation reset takes effect at the next edge.
- Priority per cycle: rst > clear > load > count_enable > hold.
- clear: count_out=0, rollover_flag=0, wrap_pulse=0, wrap_count=0, cfg_err=0.
- load: count_out=load_val with no range check. rollover_flag=(load_val==terminal(count_down)); wrap_pulse=0. wrap_count and cfg_err are unchanged.
- Terminal value: R for up, 1 for down.
- Step, up (count_down=0), with C=count_out:
  - C<R: next=C+1.
  - C>=R, wrap mode: next=1, wrap event.
  - C>=R, sat mode: next=R, no wrap event.
- Step, down (count_down=1):
  - 1<C<=R: next=C-1.
  - C>R: next=R (clamp), no wrap.
  - C<=1, wrap mode: next=R, wrap event.
  - C<=1, sat mode: next=C (hold), no wrap event.
- rollover_flag after a step is (next==terminal(count_down)). It holds its value on idle cycles. Latency: rising edge coincides with count_out reaching the terminal.
- Compatibility: the up/wrap sequence from 0 with R=N is 1,2,...,N,1,2,...; the flag is high exactly while count_out==N. This matches the previous generation.
- wrap_pulse: registered; 1 for exactly the cycle after a wrap-event edge, otherwise 0. Back-to-back wraps (e.g. R=1) give continuous 1.
- wrap_count: +1 per wrap event. Saturates at 2^WRAP_BITS-1 and does not roll over.
- rollover_val==0 with count_enable=1 (and no clear/load): count_out and rollover_flag hold, no wrap, cfg_err set. cfg_err is cleared only by rst or clear.
- Direction change mid-count: the next step uses the new direction immediately; no extra latency.
- All arithmetic is unsigned, NUM_CNT_BITS wide; C+1 cannot overflow because C<R<=max.

Optional Feature:
- Macro: FLEX_CNT_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE_BITS (default 4) and input prescale_val [PRESCALE_BITS].
  - An internal prescaler counts enabled cycles. The counter steps only on the enabled cycle where prescaler==prescale_val, after which the prescaler returns to 0. prescale_val=0 means a step every enabled cycle.
  - The prescaler resets to 0 on rst, clear or load, and holds when count_enable=0.
- Undefined: no port or parameter is added; every enabled cycle is a step.

Test Plan:
- Reset then up/wrap, R=4, enable 10 cycles -> count_out 1,2,3,4,1,2,3,4,1,2; flag high at each 4; wrap_pulse at each post-4 "1"; wrap_count=2.
- Down/wrap, R=5, load 3 then enable 6 cycles -> 2,1,5,4,3,2; flag high at 1; wrap_pulse with first 5; wrap_count=1.
- Saturate, R=3, up for 5 cycles from 0 -> 1,2,3,3,3, no wrap_pulse; then count_down=1 for 4 cycles -> 2,1,1,1.
- Simultaneous clear+load+enable with count_out=2 -> next count_out=0, flags 0; load+enable with load_val=7, R=7, up -> count_out=7, flag=1; next enabled step -> 1, wrap_pulse=1.
- rollover_val=0, enable 3 cycles with count_out=2 -> count_out stays 2, cfg_err=1 and sticky; clear -> cfg_err=0, count_out=0.
- WRAP_BITS=2, R=1 up/wrap, enable 6 cycles -> wrap_count 1,2,3,3,3,3 and wrap_pulse continuously 1; rst asserted mid-run -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/flex_counter_updown.sv
// Up/down rollover counter with load, wrap/saturate modes, wrap pulse/count and config-error flag.
// Optional prescaler enabled by defining FLEX_CNT_PRESCALE_EN.
module flex_counter_updown #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned WRAP_BITS    = 8
`ifdef FLEX_CNT_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE_BITS = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    count_down,
  input  logic                    sat_mode,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
`ifdef FLEX_CNT_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse,
  output logic [WRAP_BITS-1:0]    wrap_count,
  output logic                    cfg_err
);

  localparam int unsigned CW = NUM_CNT_BITS;
  localparam int unsigned WW = WRAP_BITS;

  logic [CW-1:0] count_q, count_d;
  logic          flag_q, flag_d;
  logic          pulse_q, pulse_d;
  logic [WW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic          err_q, err_d;

  logic [CW-1:0] term_c;
  logic [CW-1:0] nxt_c;
  logic          wrap_c;
  logic          step_ok_c;

`ifdef FLEX_CNT_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] psc_q, psc_d;

  assign step_ok_c = (psc_q == prescale_val);

  // Prescaler counts enabled cycles; restarts on clear/load or after a step.
  always_comb begin
    psc_d = psc_q;
    if (clear || load) begin
      psc_d = '0;
    end else if (count_enable) begin
      psc_d = step_ok_c ? '0 : psc_q + PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end
`else
  assign step_ok_c = 1'b1;
`endif

  assign term_c = count_down ? CW'(1) : rollover_val;

  // Candidate next count for a single step in the current direction.
  always_comb begin
    nxt_c  = count_q;
    wrap_c = 1'b0;
    if (!count_down) begin
      if (count_q < rollover_val) begin
        nxt_c = count_q + CW'(1);
      end else if (sat_mode) begin
        nxt_c = rollover_val;
      end else begin
        nxt_c  = CW'(1);
        wrap_c = 1'b1;
      end
    end else begin
      if (count_q > rollover_val) begin
        nxt_c = rollover_val;
      end else if (count_q > CW'(1)) begin
        nxt_c = count_q - CW'(1);
      end else if (!sat_mode) begin
        nxt_c  = rollover_val;
        wrap_c = 1'b1;
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    flag_d     = flag_q;
    pulse_d    = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    if (clear) begin
      count_d    = '0;
      flag_d     = 1'b0;
      wrap_cnt_d = '0;
      err_d      = 1'b0;
    end else if (load) begin
      count_d = load_val;
      flag_d  = (load_val == term_c);
    end else if (count_enable && step_ok_c) begin
      if (rollover_val == '0) begin
        // Zero terminal is a configuration error: hold the count and flag it.
        err_d = 1'b1;
      end else begin
        count_d = nxt_c;
        flag_d  = (nxt_c == term_c);
        pulse_d = wrap_c;
        if (wrap_c && (wrap_cnt_q != {WW{1'b1}})) begin
          wrap_cnt_d = wrap_cnt_q + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      flag_q     <= 1'b0;
      pulse_q    <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      flag_q     <= flag_d;
      pulse_q    <= pulse_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = pulse_q;
  assign wrap_count    = wrap_cnt_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_flex_counter_updown.sv
// Self-checking bench for flex_counter_updown: directed scenarios plus randomized run against a behavioural model.
module tb_flex_counter_updown;

  localparam int unsigned CW   = 4;
  localparam int unsigned WB   = 2;
  localparam int          WMAX = (1 << WB) - 1;

  logic          clk = 1'b0;
  logic          rst, clear, count_enable, count_down, sat_mode, load;
  logic [CW-1:0] load_val, rollover_val;
  logic [CW-1:0] count_out;
  logic          rollover_flag, wrap_pulse, cfg_err;
  logic [WB-1:0] wrap_count;
`ifdef FLEX_CNT_PRESCALE_EN
  logic [3:0]    prescale_val = 4'd0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_cnt, m_wc;
  bit m_flag, m_pulse, m_err;

  flex_counter_updown #(.NUM_CNT_BITS(CW), .WRAP_BITS(WB)) dut (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .sat_mode(sat_mode), .load(load),
    .load_val(load_val), .rollover_val(rollover_val),
`ifdef FLEX_CNT_PRESCALE_EN
    .prescale_val(prescale_val),
`endif
    .count_out(count_out), .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference: apply the per-cycle rules to integer state.
  task automatic model_edge();
    int r, c, nxt, term;
    bit wrap;
    r    = int'(rollover_val);
    term = count_down ? 1 : r;
    if (rst || clear) begin
      m_cnt = 0; m_flag = 0; m_pulse = 0; m_wc = 0; m_err = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_flag = (m_cnt == term); m_pulse = 0;
    end else if (count_enable) begin
      m_pulse = 0;
      if (r == 0) begin
        m_err = 1;
      end else begin
        c = m_cnt; wrap = 0;
        if (!count_down) begin
          if (c < r) nxt = c + 1;
          else if (sat_mode) nxt = r;
          else begin nxt = 1; wrap = 1; end
        end else begin
          if (c > r) nxt = r;
          else if (c > 1) nxt = c - 1;
          else if (sat_mode) nxt = c;
          else begin nxt = r; wrap = 1; end
        end
        m_cnt = nxt; m_flag = (nxt == term); m_pulse = wrap;
        if (wrap && m_wc < WMAX) m_wc = m_wc + 1;
      end
    end else begin
      m_pulse = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; load = 0; count_enable = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; count_down = 0; sat_mode = 0;
    load_val = '0; rollover_val = 4'd4;
    tick(); tick();
    rst = 0;
    n_checks++;
    if ({count_out, rollover_flag, wrap_pulse, wrap_count, cfg_err} !== '0)
      $display("FAIL reset: count=%0d flag=%b pulse=%b wc=%0d err=%b, want all 0",
               count_out, rollover_flag, wrap_pulse, wrap_count, cfg_err);
    else n_pass++;
  endtask

  task automatic test_up_wrap();
    int exp_c[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
    idle_inputs(); rollover_val = 4'd4; count_down = 0; sat_mode = 0; count_enable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (count_out !== CW'(exp_c[i]) || rollover_flag !== (exp_c[i] == 4) ||
          wrap_pulse !== (i == 4 || i == 8))
        $display("FAIL up_wrap[%0d]: count=%0d flag=%b pulse=%b, want count=%0d flag=%b pulse=%b",
                 i, count_out, rollover_flag, wrap_pulse, exp_c[i], exp_c[i] == 4, (i == 4 || i == 8));
      else n_pass++;
    end
    count_enable = 0;
    n_checks++;
    if (wrap_count !== WB'(2)) $display("FAIL up_wrap_count: got %0d want 2", wrap_count);
    else n_pass++;
  endtask

  task automatic test_down_wrap();
    int exp_c[6] = '{2, 1, 5, 4, 3, 2};
    idle_inputs(); clear = 1; tick(); clear = 0;
    rollover_val = 4'd5; count_down = 1; sat_mode = 0;
    load = 1; load_val = 4'd3; tick(); load = 0;
    count_enable = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (count_out !== CW'(exp_c[i]) || rollover_flag !== (i == 1) || wrap_pulse !== (i == 2))
        $display("FAIL down_wrap[%0d]: count=%0d flag=%b pulse=%b, want count=%0d flag=%b pulse=%b",
                 i, count_out, rollover_flag, wrap_pulse, exp_c[i], i == 1, i == 2);
      else n_pass++;
    end
    count_enable = 0;
    n_checks++;
    if (wrap_count !== WB'(1)) $display("FAIL down_wrap_count: got %0d want 1", wrap_count);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int exp_c[9] = '{1, 2, 3, 3, 3, 2, 1, 1, 1};
    idle_inputs(); clear = 1; tick(); clear = 0;
    rollover_val = 4'd3; sat_mode = 1; count_down = 0; count_enable = 1;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) count_down = 1;
      tick();
      n_checks++;
      if (count_out !== CW'(exp_c[i]) || wrap_pulse !== 1'b0 || wrap_count !== '0)
        $display("FAIL saturate[%0d]: count=%0d pulse=%b wc=%0d, want count=%0d pulse=0 wc=0",
                 i, count_out, wrap_pulse, wrap_count, exp_c[i]);
      else n_pass++;
    end
    count_enable = 0; sat_mode = 0;
  endtask

  task automatic test_priority();
    idle_inputs(); count_down = 0; sat_mode = 0; rollover_val = 4'd7;
    load = 1; load_val = 4'd2; tick();
    clear = 1; load = 1; count_enable = 1; load_val = 4'd5; tick();
    clear = 0;
    n_checks++;
    if (count_out !== '0 || rollover_flag !== 1'b0 || wrap_pulse !== 1'b0)
      $display("FAIL clear_prio: count=%0d flag=%b pulse=%b, want 0 0 0", count_out, rollover_flag, wrap_pulse);
    else n_pass++;
    load_val = 4'd7; tick();
    n_checks++;
    if (count_out !== 4'd7 || rollover_flag !== 1'b1)
      $display("FAIL load_prio: count=%0d flag=%b, want 7 1", count_out, rollover_flag);
    else n_pass++;
    load = 0; tick();
    n_checks++;
    if (count_out !== 4'd1 || wrap_pulse !== 1'b1 || rollover_flag !== 1'b0)
      $display("FAIL load_then_wrap: count=%0d pulse=%b flag=%b, want 1 1 0", count_out, wrap_pulse, rollover_flag);
    else n_pass++;
    count_enable = 0;
  endtask

  task automatic test_cfg_err();
    idle_inputs(); count_down = 0; rollover_val = 4'd6;
    load = 1; load_val = 4'd2; tick(); load = 0;
    rollover_val = 4'd0; count_enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (count_out !== 4'd2 || cfg_err !== 1'b1 || wrap_pulse !== 1'b0)
        $display("FAIL cfg_err[%0d]: count=%0d err=%b pulse=%b, want 2 1 0", i, count_out, cfg_err, wrap_pulse);
      else n_pass++;
    end
    count_enable = 0; rollover_val = 4'd6; tick();
    n_checks++;
    if (cfg_err !== 1'b1) $display("FAIL cfg_err_sticky: got %b want 1", cfg_err);
    else n_pass++;
    clear = 1; tick(); clear = 0;
    n_checks++;
    if (cfg_err !== 1'b0 || count_out !== '0)
      $display("FAIL cfg_err_clear: err=%b count=%0d, want 0 0", cfg_err, count_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_w[6] = '{1, 2, 3, 3, 3, 3};
    idle_inputs(); rollover_val = 4'd1; count_down = 0; sat_mode = 0;
    load = 1; load_val = 4'd1; tick(); load = 0;
    count_enable = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (wrap_count !== WB'(exp_w[i]) || wrap_pulse !== 1'b1 || count_out !== 4'd1)
        $display("FAIL back_to_back[%0d]: wc=%0d pulse=%b count=%0d, want wc=%0d pulse=1 count=1",
                 i, wrap_count, wrap_pulse, count_out, exp_w[i]);
      else n_pass++;
    end
    rst = 1; tick(); rst = 0;
    n_checks++;
    if ({count_out, rollover_flag, wrap_pulse, wrap_count, cfg_err} !== '0)
      $display("FAIL mid_reset: count=%0d flag=%b pulse=%b wc=%0d err=%b, want all 0",
               count_out, rollover_flag, wrap_pulse, wrap_count, cfg_err);
    else n_pass++;
    count_enable = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(59, 0) == 0);
      clear        = ($urandom_range(29, 0) == 0);
      load         = ($urandom_range(9, 0) == 0);
      count_enable = ($urandom_range(3, 0) != 0);
      count_down   = ($urandom_range(3, 0) == 0) ? ~count_down : count_down;
      sat_mode     = ($urandom_range(15, 0) == 0) ? ~sat_mode : sat_mode;
      load_val     = CW'($urandom_range(15, 0));
      if ($urandom_range(7, 0) == 0)
        rollover_val = ($urandom_range(9, 0) == 0) ? '0 : CW'($urandom_range(15, 1));
      tick();
      n_checks++;
      if (count_out !== CW'(m_cnt) || rollover_flag !== m_flag || wrap_pulse !== m_pulse ||
          wrap_count !== WB'(m_wc) || cfg_err !== m_err)
        $display("FAIL random[%0d]: count=%0d flag=%b pulse=%b wc=%0d err=%b, want %0d %b %b %0d %b",
                 i, count_out, rollover_flag, wrap_pulse, wrap_count, cfg_err,
                 m_cnt, m_flag, m_pulse, m_wc, m_err);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_cfg_err();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
